// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain stage for a byte FIFO. Pops one byte whenever the FIFO
// is non-empty and sends it as an 8N1 UART frame (start, data LSB first, stop).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle; pop a byte when the FIFO reports non-empty
// S_FETCH | wait out the FIFO's registered read latency
// S_LOAD  | capture the popped byte, clear the baud counter
// S_START | start bit period
// S_DATA  | data bit periods, LSB first
// S_STOP  | stop bit period, byte_done raised for its final cycle
//
// All outputs are registered from the current state, so the serial line
// trails the state register by one cycle. The three idle-high cycles
// between frames therefore fall in FETCH, LOAD and the first START cycle.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t                state_q;
  logic                  rd_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  byte_done_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_WIDTH-1:0] shift_q;

  logic baud_last;
  assign baud_last = (baud_q == BAUD_LAST);

  // Sequencer: pop, wait, load, then shift the frame out with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_q        <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
    end else begin
      rd_q        <= 1'b0;
      byte_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          shift_q <= data_in;
          baud_q  <= '0;
          bit_q   <= '0;
          state_q <= S_START;
        end
        S_START: begin
          tx_q <= 1'b0;
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          tx_q <= shift_q[0];
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (baud_last) begin
            baud_q      <= '0;
            byte_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd        = rd_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO model feeding the drain stage, UART line decoder
// acting as monitor, expected bytes kept in a scoreboard queue.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         empty = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic         rd, tx, busy, byte_done;

  int tests = 0, fails = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic hold_empty = 1'b0;
  logic empty_at_edge = 1'b1;
  logic rd_prev = 1'b0;
  int cyc = 0, rd_count = 0, bd_count = 0, frames = 0, aborted = 0;
  int last_rd_cyc = -100, last_bd_cyc = -1;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .empty(empty), .data_in(data_in),
    .rd(rd), .tx(tx), .busy(busy), .byte_done(byte_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // FIFO with registered read: data valid only in the cycle after rd, junk otherwise
  always @(posedge clk) begin : fifo_model
    logic pop;
    empty_at_edge = empty;
    pop = (rd === 1'b1);
    #1;
    if (pop) begin
      chk("fifo_underflow", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) data_in = fifo_q.pop_front();
    end else begin
      data_in = 8'($urandom);
    end
    empty = hold_empty || (fifo_q.size() == 0);
  end

  // Cycle bookkeeping for rd and byte_done pulses
  always @(negedge clk) begin
    cyc++;
    if (rd === 1'b1) begin
      rd_count++;
      last_rd_cyc = cyc;
      chk("rd_while_empty", empty_at_edge, 0);
      chk("rd_pulse_width", rd_prev, 0);
    end
    rd_prev = rd;
    if (byte_done === 1'b1) begin
      bd_count++;
      last_bd_cyc = cyc;
    end
  end

  task automatic decode_frame();
    logic [9:0] bits = '0;
    logic glitch = 1'b0, bd_bad = 1'b0, ab = 1'b0;
    logic [7:0] e;
    chk("start_latency", cyc - last_rd_cyc, 3);
    for (int b = 0; b < 10; b++) begin
      for (int s = 0; s < CPB; s++) begin
        if (!(b == 0 && s == 0)) begin
          @(negedge clk); #1;
        end
        if (reset !== 1'b1) ab = 1'b1;
        if (s == 0) bits[b] = tx;
        else if (tx !== bits[b]) glitch = 1'b1;
        if (byte_done !== ((b == 9 && s == CPB-1) ? 1'b1 : 1'b0)) bd_bad = 1'b1;
      end
    end
    if (ab) begin
      aborted++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      frames++;
      chk("frame_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame_data", bits[8:1], e);
      end
      chk("start_bit", bits[0], 0);
      chk("stop_bit", bits[9], 1);
      chk("bit_glitch", glitch, 0);
      chk("byte_done_place", bd_bad, 0);
    end
  endtask

  // Monitor: decode every frame on the line and compare against the scoreboard
  initial begin
    forever begin
      @(negedge clk); #1;
      if (reset === 1'b1 && tx === 1'b0) decode_frame();
    end
  end

  task automatic wait_rd(output int rc);
    logic found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (rd === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("rd_timeout", found, 1);
    rc = cyc;
  endtask

  task automatic wait_frames(input int target, input int budget);
    logic ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frames >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("frame_timeout", ok, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r0, n0, f0, a0;
    logic all_high;
    logic [7:0] stream[7] = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};

    // reset held with data waiting
    load_byte(8'h64);
    idle_cycles(3);
    chk("rst_rd", rd, 0);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_byte_done", byte_done, 0);
    chk("rst_empty_low", empty, 0);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    chk("first_edge_rd", rd, 1);
    r = cyc;
    @(negedge clk); #1;
    chk("rd_one_cycle", rd, 0);
    chk("busy_after_pop", busy, 1);

    // single byte 8'h64
    wait_frames(1, 100);
    chk("bd_frame_cycle40", last_bd_cyc - r, 42);
    chk("busy_at_bd", busy, 1);
    @(negedge clk); #1;
    chk("busy_after_frame", busy, 0);
    chk("tx_after_frame", tx, 1);

    // back-to-back stream
    n0 = rd_count; f0 = frames;
    foreach (stream[i]) load_byte(stream[i]);
    wait_rd(r0);
    wait_frames(f0 + 7, 500);
    chk("stream_rd_count", rd_count - n0, 7);
    chk("stream_timing", last_bd_cyc - r0, 6*43 + 42);
    idle_cycles(20);
    chk("stream_idle_tx", tx, 1);
    chk("stream_idle_busy", busy, 0);
    chk("stream_idle_empty", empty, 1);
    chk("stream_no_extra_rd", rd_count - n0, 7);

    // empty guard
    hold_empty = 1'b1;
    load_byte(8'h3C);
    load_byte(8'hC3);
    n0 = rd_count; f0 = frames; all_high = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      all_high &= tx;
    end
    chk("guard_no_rd", rd_count - n0, 0);
    chk("guard_tx_high", all_high, 1);
    hold_empty = 1'b0;
    @(negedge clk); #1;
    hold_empty = 1'b1;
    idle_cycles(60);
    chk("guard_one_rd", rd_count - n0, 1);
    chk("guard_one_frame", frames - f0, 1);
    hold_empty = 1'b0;
    wait_frames(f0 + 2, 100);

    // data stability, data_in is junk outside the load cycle
    f0 = frames;
    load_byte(8'hA5);
    wait_frames(f0 + 1, 100);

    // reset during data bit 3 of 200
    a0 = aborted; f0 = frames;
    load_byte(8'd200);
    wait_rd(r);
    while (cyc < r + 3 + 4*CPB + 1) begin
      @(negedge clk); #1;
    end
    n0 = rd_count;
    #1 reset = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    idle_cycles(2);
    #1 reset = 1'b1;
    idle_cycles(60);
    chk("midrst_no_rd", rd_count - n0, 0);
    chk("midrst_no_frame", frames - f0, 0);
    chk("midrst_aborted", aborted - a0, 1);
    chk("midrst_fifo_consumed", fifo_q.size(), 0);
    chk("midrst_idle_tx", tx, 1);

    // reset during start bit: line must rise before the next clock edge
    load_byte(8'h5A);
    wait_rd(r);
    idle_cycles(4);
    chk("start_bit_low", tx, 0);
    #1 reset = 1'b0;
    #1;
    chk("async_tx_release", tx, 1);
    idle_cycles(2);
    #1 reset = 1'b1;
    idle_cycles(60);
    chk("async_aborted", aborted - a0, 2);
    chk("async_no_frame", frames - f0, 0);

    // random bytes with random empty gating
    f0 = frames;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < int'($urandom_range(0, 60)); i++) begin
        @(negedge clk); #1;
        hold_empty = ($urandom_range(0, 3) == 0);
      end
      load_byte(8'($urandom));
    end
    hold_empty = 1'b0;
    wait_frames(f0 + 6, 600);
    idle_cycles(5);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("bd_count_vs_frames", bd_count, frames);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the 8-bit FIFO; connects directly to its data_out, empty and rd.
- Whenever the FIFO is non-empty, pops one byte and serialises it as an 8N1 UART frame on a single line: start bit, 8 data bits LSB first, one stop bit.
- Pops exactly one byte per frame and never reads an empty FIFO.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- DATA_WIDTH, 8, byte width; must match the FIFO width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- empty  input  1  FIFO empty flag.
- data_in  input  DATA_WIDTH  FIFO data_out; valid in the cycle after rd is high.
- rd  output  1  FIFO read strobe; single-cycle pulse.
- tx  output  1  serial line; idles high.
- busy  output  1  high from the pop until the end of the stop bit.
- byte_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rd=0, tx=1, busy=0, byte_done=0, bit counter=0, baud counter=0, shift register=0.
- Leaving reset is synchronous. The first decision is made on the first rising edge with reset=1.
- State machine, all outputs registered:
  - IDLE: tx=1, busy=0. If empty=0, assert rd for 1 cycle and go to FETCH.
  - FETCH: rd=0. Wait one cycle to cover the FIFO's registered read latency. Go to LOAD.
  - LOAD: capture data_in into the shift register. Clear the baud counter. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index DATA_WIDTH-1 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. byte_done=1 in the final cycle of STOP. Then go to IDLE.
- busy=1 in FETCH, LOAD, START, DATA and STOP.
- Frame length is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles of tx activity.
- Latency: empty falling in cycle N (sampled at edge N) → rd high in cycle N+1 → tx falls at the start of cycle N+4.
- Back-to-back frames:
  - IDLE lasts one cycle between frames. tx stays high during IDLE/FETCH/LOAD, so the effective stop time is CLKS_PER_BIT+3 cycles.
  - No gap-less streaming is required.
- empty is ignored outside IDLE.
- rd is never asserted while empty=1 as sampled at the same edge.
- rd is at most 1 per frame.
- Reset asserted mid-frame:
  - tx returns to 1 immediately (asynchronously).
  - The partially sent byte is lost and is not re-read.
  - A pop already issued is consumed.
- Baud counter width is ceil(log2(CLKS_PER_BIT)) bits. It counts 0..CLKS_PER_BIT-1 and wraps; there is no overflow at the maximum parameter value.
- data_in is sampled only in LOAD. Changes at any other time have no effect.

Test Plan:
- Reset: hold reset=0 with empty=0 → rd=0, tx=1, busy=0, byte_done=0. Release reset → rd pulses exactly 1 cycle on the first edge.
- Single byte (CLKS_PER_BIT=4), FIFO preloaded with 100 (8'h64):
  - tx sequence, 4 cycles each: 0 | 0,0,1,0,0,1,1,0 | 1.
  - byte_done pulses once at cycle 40 of the frame.
  - busy=0 afterwards.
- Stream, FIFO model preloaded with 100, 150, 200, 40, 70, 65, 15:
  - Seven frames decoded in that order, exactly 7 rd pulses.
  - After the last frame, empty=1 and the DUT stays in IDLE with tx=1.
- Empty guard: hold empty=1 for 50 cycles → rd never asserted, tx=1. Lower empty for 1 cycle → exactly one rd pulse and one frame.
- Mid-frame reset: assert reset=0 during data bit 3 of byte 200 → tx=1 within the same cycle. After release with empty=1 → no frame.
- Data stability: toggle data_in randomly outside LOAD during a frame of 8'hA5 → serial output decodes 8'hA5.
